axi_read_arbiter: RTL
=====================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter S_ID_M0, default 4'b0001, upper slave-ID tag for master 0.
REQ-002 Parameter S_ID_M1, default 4'b0010, upper slave-ID tag for master 1.
REQ-003 ACLK  input  1  clock; all state on rising edge.
REQ-004 ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 M0_ARID/ARAddr/ARLen/ARSize/ARBurst/ARValid  input  AXI_ID_BITS/AXI_ADDR_BITS/AXI_LEN_BITS/AXI_SIZE_BITS/2/1  master-0 read address.
REQ-006 M0_ARReady  output  1  master-0 address accept.
REQ-007 M0_RID/RData/RResp/RLast/RValid  output  AXI_ID_BITS/AXI_DATA_BITS/2/1/1  master-0 read data.
REQ-008 M0_RReady  input  1  master-0 data accept.
REQ-009 M1_* ports are identical to REQ-005..REQ-008 for master 1.
REQ-010 S_ARID  output  AXI_IDS_BITS  {tag, granted ARID}; S_ARAddr/ARLen/ARSize/ARBurst/ARValid outputs mirror master widths.
REQ-011 S_ARReady  input  1  slave address accept.
REQ-012 S_RID/RData/RResp/RLast/RValid  input  AXI_IDS_BITS/AXI_DATA_BITS/2/1/1  slave read data; S_RReady output 1.
REQ-013 Grant  output  2  one-hot current owner, 2'b00 when idle.
REQ-014 Len_err  output  1  sticky flag: RLast beat count mismatched latched ARLen.

Function
REQ-015 FSM states IDLE, ADDR, DATA; the FSM never holds more than one outstanding burst.
REQ-016 In IDLE: no ARValid -> stay; one ARValid -> grant that master; both -> grant the master not granted last time; transition to ADDR on the next edge.
REQ-017 In ADDR: S_AR* driven combinationally from the granted master; granted M_ARReady = S_ARReady; S_ARValid&S_ARReady -> DATA, latch ARLen, clear beat counter.
REQ-018 In DATA: S_R* routed to the granted master with RID = S_RID[AXI_ID_BITS-1:0]; S_RReady = granted M_RReady; the non-granted M_RValid is 0.
REQ-019 Each S_RValid&S_RReady increments the AXI_LEN_BITS beat counter; a beat with S_RLast returns the FSM to IDLE and updates the last-granted pointer.
REQ-020 On an RLast beat, if the counter differs from the latched ARLen, set Len_err; Len_err clears only on reset.
REQ-021 A non-granted master sees ARReady=0 and RValid=0 at all times; its ARValid is held until it is granted.
REQ-022 In IDLE, S_ARValid=0, S_RReady=0, and Grant=00; Grant stays constant across ADDR and DATA.
REQ-023 Latency: ARValid in IDLE -> S_ARValid asserted one cycle later; no bubble between grant and forwarding; IDLE is revisited one cycle after RLast.
REQ-024 The counter wraps at 2^AXI_LEN_BITS with no saturation.

Reset
REQ-025 While ARESETn=0: state IDLE, last-granted pointer = M1 (so M0 wins the first tie), Grant=00, Len_err=0, counter=0, and all Valid/Ready outputs 0.
REQ-026 Reset mid-burst abandons the burst immediately; no R beat is forwarded after reset asserts.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined, ties resolve per REQ-016; without it, ties always grant M0 (fixed priority) and the pointer logic is absent.

Structure
REQ-028 Package axi_arb_pkg holds the state enum, the S_ID_M0/S_ID_M1 defaults, and the master-select typedef.
REQ-029 One sub-module, arb_rr2, is a 2-requester grant picker with pointer update.

Verification
REQ-030 M0 only, ARLen=3, slave returns 4 beats -> M0 receives 4 beats, RID=M0_ARID, Grant=01 throughout, Len_err=0.
REQ-031 M0 and M1 raise ARValid in the same cycle twice -> grants M0 then M1 (round-robin); fixed-priority build -> M0 then M0.
REQ-032 M1 raises ARValid during an M0 DATA phase -> M1_ARReady stays 0 until M0's RLast, then M1 is granted one cycle later.
REQ-033 ARLen=3 with the slave asserting RLast on beat 2 -> FSM returns to IDLE, Len_err=1 and stays 1.
REQ-034 ARESETn dropped during beat 2 of a 4-beat burst -> all Valid outputs 0 the same cycle, Grant=00, next request served normally.
REQ-035 Slave ARReady held low 5 cycles -> S_AR* stable, FSM stays in ADDR, and M0_ARReady mirrors the slave.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the two-master AXI read arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed M0 priority).
package axi_arb_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int TAG_BITS      = AXI_IDS_BITS - AXI_ID_BITS;

    localparam logic [TAG_BITS-1:0] S_ID_M0_DEF = 4'b0001;
    localparam logic [TAG_BITS-1:0] S_ID_M1_DEF = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } msel_t;

endpackage

// File: rtl/axi_read_arbiter_arb_rr2.sv
// Two-requester grant picker; with ARB_ROUND_ROBIN_EN it keeps a
// last-granted pointer so ties alternate, otherwise M0 always wins.
module arb_rr2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    output msel_t      pick
`ifdef ARB_ROUND_ROBIN_EN
    ,
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd,
    input  msel_t      win
`endif
);

`ifdef ARB_ROUND_ROBIN_EN
    msel_t last;

    // Remember the owner of the most recently completed burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= SEL_M1;
        end else if (upd) begin
            last <= win;
        end
    end

    // Single requester wins; a tie goes to whoever was not served last
    always_comb begin
        pick = SEL_M0;
        if (req == 2'b11) begin
            if (last == SEL_M0) begin
                pick = SEL_M1;
            end
        end else if (req == 2'b10) begin
            pick = SEL_M1;
        end
    end
`else
    // Fixed priority: M1 only when it is the sole requester
    always_comb begin
        pick = SEL_M0;
        if (req == 2'b10) begin
            pick = SEL_M1;
        end
    end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter, one burst in flight at a time.
// ARB_ROUND_ROBIN_EN enables round-robin ties; default is fixed M0 priority.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter logic [TAG_BITS-1:0] S_ID_M0 = S_ID_M0_DEF,
    parameter logic [TAG_BITS-1:0] S_ID_M1 = S_ID_M1_DEF
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [AXI_ID_BITS-1:0]   M0_ARID,
    input  logic [AXI_ADDR_BITS-1:0] M0_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  M0_ARLen,
    input  logic [AXI_SIZE_BITS-1:0] M0_ARSize,
    input  logic [1:0]               M0_ARBurst,
    input  logic                     M0_ARValid,
    output logic                     M0_ARReady,
    output logic [AXI_ID_BITS-1:0]   M0_RID,
    output logic [AXI_DATA_BITS-1:0] M0_RData,
    output logic [1:0]               M0_RResp,
    output logic                     M0_RLast,
    output logic                     M0_RValid,
    input  logic                     M0_RReady,
    input  logic [AXI_ID_BITS-1:0]   M1_ARID,
    input  logic [AXI_ADDR_BITS-1:0] M1_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  M1_ARLen,
    input  logic [AXI_SIZE_BITS-1:0] M1_ARSize,
    input  logic [1:0]               M1_ARBurst,
    input  logic                     M1_ARValid,
    output logic                     M1_ARReady,
    output logic [AXI_ID_BITS-1:0]   M1_RID,
    output logic [AXI_DATA_BITS-1:0] M1_RData,
    output logic [1:0]               M1_RResp,
    output logic                     M1_RLast,
    output logic                     M1_RValid,
    input  logic                     M1_RReady,
    output logic [AXI_IDS_BITS-1:0]  S_ARID,
    output logic [AXI_ADDR_BITS-1:0] S_ARAddr,
    output logic [AXI_LEN_BITS-1:0]  S_ARLen,
    output logic [AXI_SIZE_BITS-1:0] S_ARSize,
    output logic [1:0]               S_ARBurst,
    output logic                     S_ARValid,
    input  logic                     S_ARReady,
    input  logic [AXI_IDS_BITS-1:0]  S_RID,
    input  logic [AXI_DATA_BITS-1:0] S_RData,
    input  logic [1:0]               S_RResp,
    input  logic                     S_RLast,
    input  logic                     S_RValid,
    output logic                     S_RReady,
    output logic [1:0]               Grant,
    output logic                     Len_err
);

    state_t                  state;
    state_t                  state_nxt;
    msel_t                   sel;
    msel_t                   pick;
    logic [AXI_LEN_BITS-1:0] len_q;
    logic [AXI_LEN_BITS-1:0] cnt;
    logic                    len_err_q;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    r_end;
    logic                    tag_unused;

    assign ar_hs      = S_ARValid & S_ARReady;
    assign r_hs       = S_RValid & S_RReady;
    assign r_end      = r_hs & S_RLast;
    assign tag_unused = ^S_RID[AXI_IDS_BITS-1:AXI_ID_BITS];
    assign Len_err    = len_err_q;

    arb_rr2 u_pick (
        .req  ({M1_ARValid, M0_ARValid}),
        .pick (pick)
`ifdef ARB_ROUND_ROBIN_EN
        ,
        .clk  (ACLK),
        .rst_n(ARESETn),
        .upd  (state == DATA && r_end),
        .win  (sel)
`endif
    );

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant, address handshake, then data until RLast
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (M0_ARValid || M1_ARValid) state_nxt = ADDR;
            ADDR: if (ar_hs) state_nxt = DATA;
            DATA: if (r_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner, latched length, beat counter and sticky length error
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sel       <= SEL_M0;
            len_q     <= '0;
            cnt       <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (state == IDLE && (M0_ARValid || M1_ARValid)) begin
                sel <= pick;
            end
            if (state == ADDR && ar_hs) begin
                len_q <= S_ARLen;
                cnt   <= '0;
            end
            if (state == DATA && r_hs) begin
                cnt <= cnt + 1'b1;
                if (S_RLast && cnt != len_q) begin
                    len_err_q <= 1'b1;
                end
            end
        end
    end

    // Outputs: mux the owner's AR channel, route R beats, gate handshakes
    always_comb begin
        S_ARID     = {S_ID_M0, M0_ARID};
        S_ARAddr   = M0_ARAddr;
        S_ARLen    = M0_ARLen;
        S_ARSize   = M0_ARSize;
        S_ARBurst  = M0_ARBurst;
        if (sel == SEL_M1) begin
            S_ARID    = {S_ID_M1, M1_ARID};
            S_ARAddr  = M1_ARAddr;
            S_ARLen   = M1_ARLen;
            S_ARSize  = M1_ARSize;
            S_ARBurst = M1_ARBurst;
        end
        M0_RID     = S_RID[AXI_ID_BITS-1:0];
        M0_RData   = S_RData;
        M0_RResp   = S_RResp;
        M0_RLast   = S_RLast;
        M1_RID     = S_RID[AXI_ID_BITS-1:0];
        M1_RData   = S_RData;
        M1_RResp   = S_RResp;
        M1_RLast   = S_RLast;
        S_ARValid  = 1'b0;
        M0_ARReady = 1'b0;
        M1_ARReady = 1'b0;
        S_RReady   = 1'b0;
        M0_RValid  = 1'b0;
        M1_RValid  = 1'b0;
        Grant      = 2'b00;
        if (state != IDLE) begin
            Grant = (sel == SEL_M1) ? 2'b10 : 2'b01;
        end
        unique case (state)
            ADDR: begin
                S_ARValid  = (sel == SEL_M1) ? M1_ARValid : M0_ARValid;
                M0_ARReady = (sel == SEL_M0) & S_ARReady;
                M1_ARReady = (sel == SEL_M1) & S_ARReady;
            end
            DATA: begin
                S_RReady  = (sel == SEL_M1) ? M1_RReady : M0_RReady;
                M0_RValid = (sel == SEL_M0) & S_RValid;
                M1_RValid = (sel == SEL_M1) & S_RValid;
            end
            default: ;
        endcase
    end

endmodule
